// File: rtl/sfx_pkg.sv
// Shared types and defaults for the game sound-effect scheduler.
// Holds the FSM state encoding, event source indices and track-ID defaults.
package sfx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BGM_REQ   = 3'd1,
    ST_BGM_PLAY  = 3'd2,
    ST_SFX_REQ   = 3'd3,
    ST_SFX_PLAY  = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  localparam int SRC_MOVE   = 0;
  localparam int SRC_CHANGE = 2;
  localparam int SRC_OVER   = 3;

  localparam int DEF_NUM_SRC  = 4;
  localparam int DEF_ID_W     = 3;
  localparam int DEF_BGM_ID   = 0;
  localparam int DEF_SFX_BASE = 1;

  // Index width for a source count; a single source still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfx_prio_enc.sv
// Fixed-priority encoder: the highest set request index wins.
// o_any flags that at least one request is present.
module sfx_prio_enc
  import sfx_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_any
);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_req[i]) o_grant = IDX_W'(i);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/sfx_scheduler.sv
// Arbitrates game event pulses into MP3 track requests and loops background music.
// Optional build macro SFX_SCHED_PREEMPT_EN lets a higher-priority effect cut the current one.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int ID_W     = DEF_ID_W,
  parameter int BGM_ID   = DEF_BGM_ID,
  parameter int SFX_BASE = DEF_SFX_BASE,
  parameter int MIN_GAP  = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_active,
  input  logic [NUM_SRC-1:0] evt,
  output logic               play_valid,
  output logic [ID_W-1:0]    play_id,
  input  logic               play_ready,
  input  logic               track_done,
  output logic [NUM_SRC-1:0] cur_src,
  output logic               busy
);

  localparam int IDX_W = idx_w(NUM_SRC);
  localparam int CNT_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [ID_W-1:0]  BGM_TRK  = ID_W'(BGM_ID);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP - 1);

  state_t               r_state;
  logic [NUM_SRC-1:0]   r_pending;
  logic [IDX_W-1:0]     r_grant;
  logic [CNT_W-1:0]     r_gap_cnt;
  logic                 r_play_valid;
  logic [ID_W-1:0]      r_play_id;
  logic [NUM_SRC-1:0]   r_cur_src;
  logic                 r_busy;

  logic [IDX_W-1:0]     w_grant;
  logic                 w_any;
  logic                 w_xfer;
  logic [NUM_SRC-1:0]   w_clr;
  logic                 w_preempt;

  function automatic logic [ID_W-1:0] f_sfx_id(input logic [IDX_W-1:0] g);
    return ID_W'(SFX_BASE + int'(g));
  endfunction

  function automatic logic [NUM_SRC-1:0] f_onehot(input logic [IDX_W-1:0] g);
    logic [NUM_SRC-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  sfx_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio (
    .i_req   (r_pending),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign w_xfer = r_play_valid & play_ready;

  always_comb begin
    w_clr = '0;
    if (w_xfer && r_state == ST_SFX_REQ) w_clr = f_onehot(r_grant);
  end

`ifdef SFX_SCHED_PREEMPT_EN
  // r_grant still names the playing source while in SFX_PLAY.
  assign w_preempt = w_any && (w_grant > r_grant);
`else
  assign w_preempt = 1'b0;
`endif

  // Pending latch: a new pulse wins over the clear of its own transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else if (!game_active) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | evt;
    end
  end

  // Request FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_gap_cnt    <= '0;
      r_play_valid <= 1'b0;
      r_play_id    <= '0;
      r_cur_src    <= '0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (game_active) begin
            r_busy       <= 1'b1;
            r_play_valid <= 1'b1;
            if (w_any) begin
              r_state   <= ST_SFX_REQ;
              r_grant   <= w_grant;
              r_play_id <= f_sfx_id(w_grant);
            end else begin
              r_state   <= ST_BGM_REQ;
              r_play_id <= BGM_TRK;
            end
          end
        end

        ST_BGM_REQ: begin
          if (w_xfer) begin
            r_state      <= ST_BGM_PLAY;
            r_play_valid <= 1'b0;
          end else if (w_any) begin
            // Only withdrawal allowed: an effect displaces a not-yet-accepted BGM request.
            r_state   <= ST_SFX_REQ;
            r_grant   <= w_grant;
            r_play_id <= f_sfx_id(w_grant);
          end
        end

        ST_BGM_PLAY: begin
          if (w_any) begin
            r_state      <= ST_SFX_REQ;
            r_grant      <= w_grant;
            r_play_id    <= f_sfx_id(w_grant);
            r_play_valid <= 1'b1;
          end else if (track_done) begin
            r_state      <= ST_BGM_REQ;
            r_play_id    <= BGM_TRK;
            r_play_valid <= 1'b1;
          end else if (!game_active) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_SFX_REQ: begin
          if (w_xfer) begin
            r_state      <= ST_SFX_PLAY;
            r_play_valid <= 1'b0;
            r_cur_src    <= f_onehot(r_grant);
          end
        end

        ST_SFX_PLAY: begin
          if (w_preempt) begin
            r_state      <= ST_SFX_REQ;
            r_grant      <= w_grant;
            r_play_id    <= f_sfx_id(w_grant);
            r_play_valid <= 1'b1;
            r_cur_src    <= '0;
          end else if (track_done) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_LOAD;
            r_cur_src <= '0;
          end
        end

        ST_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end else if (w_any) begin
            r_state      <= ST_SFX_REQ;
            r_grant      <= w_grant;
            r_play_id    <= f_sfx_id(w_grant);
            r_play_valid <= 1'b1;
          end else if (game_active) begin
            r_state      <= ST_BGM_REQ;
            r_play_id    <= BGM_TRK;
            r_play_valid <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_play_valid <= 1'b0;
          r_cur_src    <= '0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign play_valid = r_play_valid;
  assign play_id    = r_play_id;
  assign cur_src    = r_cur_src;
  assign busy       = r_busy;

`ifndef SYNTHESIS
  // An effect request, once raised, holds its track ID until accepted.
  a_id_hold: assert property (
    @(posedge clk) disable iff (rst)
      (r_play_valid && !play_ready && r_state == ST_SFX_REQ)
        |=> (r_play_valid && $stable(r_play_id))
  );

  a_cur_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(r_cur_src)
  );
`endif

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_sfx_scheduler;
  import sfx_pkg::*;

  localparam int NS  = 4;
  localparam int IDW = 3;
  localparam int GAP = 4;
`ifdef SFX_SCHED_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           game_active = 1'b0;
  logic [NS-1:0]  evt = '0;
  logic           play_ready = 1'b0;
  logic           track_done = 1'b0;
  logic           play_valid;
  logic [IDW-1:0] play_id;
  logic [NS-1:0]  cur_src;
  logic           busy;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sfx_scheduler #(
    .NUM_SRC  (NS),
    .ID_W     (IDW),
    .BGM_ID   (0),
    .SFX_BASE (1),
    .MIN_GAP  (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_active (game_active),
    .evt         (evt),
    .play_valid  (play_valid),
    .play_id     (play_id),
    .play_ready  (play_ready),
    .track_done  (track_done),
    .cur_src     (cur_src),
    .busy        (busy)
  );

  // Model: what the player has been asked for, what it is playing, and the silence left.
  bit m_pend[NS];
  bit m_req      = 1'b0;
  bit m_req_bgm  = 1'b0;
  int m_req_src  = 0;
  int m_play     = 0;    // 0 nothing, 1 background music, 2 effect
  int m_src      = 0;
  int m_gap      = -1;   // cycles of silence still owed, -1 when not in a gap

  function automatic int top_pending();
    for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) return i;
    return -1;
  endfunction

  task automatic ask(input int src);
    m_req     = 1'b1;
    m_req_bgm = (src < 0);
    m_req_src = src;
    m_play    = 0;
    m_gap     = -1;
  endtask

  always @(posedge clk) begin
    int hi;
    bit xfer;
    hi   = top_pending();
    xfer = m_req && play_ready;
    if (rst) begin
      for (int i = 0; i < NS; i++) m_pend[i] = 1'b0;
      m_req = 1'b0; m_req_bgm = 1'b0; m_play = 0; m_gap = -1;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (!game_active) m_pend[i] = 1'b0;
        else m_pend[i] = evt[i] || (m_pend[i] && !(xfer && !m_req_bgm && m_req_src == i));
      end
      if (m_req) begin
        if (xfer) begin
          m_req  = 1'b0;
          m_play = m_req_bgm ? 1 : 2;
          m_src  = m_req_src;
        end else if (m_req_bgm && hi >= 0) begin
          ask(hi);
        end
      end else if (m_play == 1) begin
        if (hi >= 0) ask(hi);
        else if (track_done) ask(-1);
        else if (!game_active) m_play = 0;
      end else if (m_play == 2) begin
        if (PREEMPT && hi > m_src) ask(hi);
        else if (track_done) begin m_play = 0; m_gap = GAP - 1; end
      end else if (m_gap >= 0) begin
        if (m_gap > 0) m_gap--;
        else if (hi >= 0) ask(hi);
        else if (game_active) ask(-1);
        else m_gap = -1;
      end else if (game_active) begin
        ask(hi >= 0 ? hi : -1);
      end
    end
  end

  always @(negedge clk) begin
    logic           e_valid;
    logic           e_busy;
    logic [IDW-1:0] e_id;
    logic [NS-1:0]  e_cur;
    if (cmp_en) begin
      e_valid = m_req;
      e_busy  = m_req || (m_play != 0) || (m_gap >= 0);
      e_id    = IDW'(m_req_bgm ? 0 : 1 + m_req_src);
      e_cur   = (m_play == 2) ? (NS'(1) << m_src) : '0;
      total++;
      if (play_valid !== e_valid || busy !== e_busy || cur_src !== e_cur ||
          (e_valid && play_id !== e_id)) begin
        bad++;
        $display("FAIL model t=%0t valid=%b/%b id=%0d/%0d cur=%b/%b busy=%b/%b (got/want)",
                 $time, play_valid, e_valid, play_id, e_id, cur_src, e_cur, busy, e_busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    cmp_en = 1'b1;
    chk("reset_valid", 32'(play_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cur", 32'(cur_src), 0);

    // Background music request, acceptance and loop
    rst = 1'b0; game_active = 1'b1; play_ready = 1'b1;
    tick();
    chk("bgm_req_valid", 32'(play_valid), 1);
    chk("bgm_req_id", 32'(play_id), 0);
    tick();
    chk("bgm_play_valid", 32'(play_valid), 0);
    chk("bgm_play_busy", 32'(busy), 1);
    track_done = 1'b1; tick(); track_done = 1'b0;
    chk("bgm_loop_valid", 32'(play_valid), 1);
    chk("bgm_loop_id", 32'(play_id), 0);
    tick();

    // Move effect held against a stalled player
    play_ready = 1'b0; evt = 4'b0001 << SRC_MOVE; tick(); evt = '0; tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 32'(play_valid), 1);
      chk("hold_id", 32'(play_id), 1);
      tick();
    end
    play_ready = 1'b1; tick();
    chk("move_cur", 32'(cur_src), 32'h1);
    chk("move_xfer_valid", 32'(play_valid), 0);

    // Simultaneous move and over: over first, then the gap, then move
    track_done = 1'b1; tick(); track_done = 1'b0;
    evt = (4'b0001 << SRC_MOVE) | (4'b0001 << SRC_OVER); tick(); evt = '0;
    tick(); tick(); tick();
    chk("over_first_valid", 32'(play_valid), 1);
    chk("over_first_id", 32'(play_id), 4);
    tick();
    chk("over_cur", 32'(cur_src), 32'h8);
    track_done = 1'b1; tick(); track_done = 1'b0;
    chk("gap_idle", 32'(play_valid), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gap_idle", 32'(play_valid), 0);
    end
    tick();
    chk("after_gap_valid", 32'(play_valid), 1);
    chk("after_gap_id", 32'(play_id), 1);
    tick();
    chk("move2_cur", 32'(cur_src), 32'h1);

`ifdef SFX_SCHED_PREEMPT_EN
    // Over event cuts the move effect with no gap
    evt = 4'b0001 << SRC_OVER; tick(); evt = '0; tick();
    chk("preempt_valid", 32'(play_valid), 1);
    chk("preempt_id", 32'(play_id), 4);
    chk("preempt_cur", 32'(cur_src), 0);
    tick();
    chk("preempt_play_cur", 32'(cur_src), 32'h8);
    track_done = 1'b1; tick(); track_done = 1'b0;
`else
    // Three change pulses collapse into one request
    for (int k = 0; k < 3; k++) begin
      evt = 4'b0001 << SRC_CHANGE; tick(); evt = '0; tick();
    end
    chk("change_wait_valid", 32'(play_valid), 0);
    track_done = 1'b1; tick(); track_done = 1'b0;
    tick(); tick(); tick(); tick();
    chk("change_valid", 32'(play_valid), 1);
    chk("change_id", 32'(play_id), 3);
    tick();
    chk("change_cur", 32'(cur_src), 32'h4);
    track_done = 1'b1; tick(); track_done = 1'b0;
    tick(); tick(); tick(); tick();
    chk("single_change_valid", 32'(play_valid), 1);
    chk("single_change_id", 32'(play_id), 0);
    tick();

    // Over waits for the move effect to finish plus the gap
    evt = 4'b0001 << SRC_MOVE; tick(); evt = '0; tick(); tick();
    evt = 4'b0001 << SRC_OVER; tick(); evt = '0; tick();
    chk("no_preempt_valid", 32'(play_valid), 0);
    chk("no_preempt_cur", 32'(cur_src), 32'h1);
    track_done = 1'b1; tick(); track_done = 1'b0;
    tick(); tick(); tick();
    chk("late_over_gap", 32'(play_valid), 0);
    tick();
    chk("late_over_valid", 32'(play_valid), 1);
    chk("late_over_id", 32'(play_id), 4);
    tick();
`endif

    // Reset in the middle of a handshake
    rst = 1'b1; tick(); rst = 1'b0;
    play_ready = 1'b0; game_active = 1'b1; tick();
    chk("pre_rst_valid", 32'(play_valid), 1);
    rst = 1'b1; evt = 4'b0001 << SRC_CHANGE; tick(); rst = 1'b0; evt = '0;
    chk("rst_drop_valid", 32'(play_valid), 0);
    chk("rst_drop_busy", 32'(busy), 0);
    chk("rst_drop_cur", 32'(cur_src), 0);
    tick();
    chk("rst_pending_valid", 32'(play_valid), 1);
    chk("rst_pending_id", 32'(play_id), 0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) game_active = ~game_active;
      for (int i = 0; i < NS; i++) evt[i] = ($urandom_range(0, 15) == 0);
      play_ready = 1'($urandom_range(0, 1));
      track_done = ($urandom_range(0, 11) == 0);
      rst        = ($urandom_range(0, 799) == 0);
      tick();
    end
    rst = 1'b0; evt = '0; track_done = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
